reg_file_sb: RTL and testbench



---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_file_sb_if.sv | 32 +++
 rtl/reg_file_sb_scoreboard.sv | 51 +++++
 rtl/reg_file_sb.sv | 115 +++++++++++
 tb/tb_reg_file_sb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package reg_file_pkg;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   localparam int unsigned MAX_DEPTH = 256;

   function automatic int unsigned depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the register file.
interface reg_file_sb_if #(
   parameter int unsigned WORD_LENGTH = 8,
   parameter int unsigned ADDR_WIDTH  = 3
);
   logic                   reg_Write;
   logic [ADDR_WIDTH-1:0]  Write_Register;
   logic [WORD_LENGTH-1:0] Write_Data;
   logic                   Reserve_En;
   logic [ADDR_WIDTH-1:0]  Reserve_Register;
   logic [ADDR_WIDTH-1:0]  Read_Register_1;
   logic [ADDR_WIDTH-1:0]  Read_Register_2;
   logic [WORD_LENGTH-1:0] Read_Data_1;
   logic [WORD_LENGTH-1:0] Read_Data_2;
   logic                   Read_Valid_1;
   logic                   Read_Valid_2;
   logic                   Clear_Start;
   logic                   Busy;
   logic [ADDR_WIDTH:0]    Pending_Count;

   modport master (
      output reg_Write, Write_Register, Write_Data, Reserve_En, Reserve_Register,
             Read_Register_1, Read_Register_2, Clear_Start,
      input  Read_Data_1, Read_Data_2, Read_Valid_1, Read_Valid_2, Busy, Pending_Count
   );

   modport slave (
      input  reg_Write, Write_Register, Write_Data, Reserve_En, Reserve_Register,
             Read_Register_1, Read_Register_2, Clear_Start,
      output Read_Data_1, Read_Data_2, Read_Valid_1, Read_Valid_2, Busy, Pending_Count
   );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending bits with reserve/write/clear updates and registered popcount.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_reserve_en,
   input  logic [ADDR_WIDTH-1:0]           i_reserve_addr,
   input  logic                            i_write_en,
   input  logic [ADDR_WIDTH-1:0]           i_write_addr,
   input  logic                            i_clear_en,
   input  logic [ADDR_WIDTH-1:0]           i_clear_addr,
   output logic [depth(ADDR_WIDTH)-1:0]    o_pending,
   output logic [ADDR_WIDTH:0]             o_count
);
   localparam int unsigned DEPTH = depth(ADDR_WIDTH);
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   logic [DEPTH-1:0]     r_pending;
   logic [DEPTH-1:0]     w_pending_next;
   logic [MAX_DEPTH-1:0] w_pending_ext;
   logic [CW-1:0]        r_count;

   // Reserve is applied last so it wins over a same-cycle write to that register.
   always_comb begin
      w_pending_next = r_pending;
      if (i_clear_en) w_pending_next[i_clear_addr] = 1'b0;
      if (i_write_en) w_pending_next[i_write_addr] = 1'b0;
      if (i_reserve_en) w_pending_next[i_reserve_addr] = 1'b1;
   end

   always_comb begin
      w_pending_ext = '0;
      w_pending_ext[DEPTH-1:0] = w_pending_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
         r_count   <= '0;
      end else begin
         r_pending <= w_pending_next;
         r_count   <= CW'(popcount(w_pending_ext));
      end
   end

   assign o_pending = r_pending;
   assign o_count   = r_count;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-to-read bypass, pending scoreboard and sequenced clear sweep.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int unsigned WORD_LENGTH = 8,
   parameter int unsigned ADDR_WIDTH  = 3,
   parameter bit          ZERO_REG    = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   reg_file_sb_if.slave  bus
);
   localparam int unsigned DEPTH = depth(ADDR_WIDTH);

   state_t                 r_state, w_state_next;
   logic [ADDR_WIDTH-1:0]  r_cnt, w_cnt_next;
   logic [WORD_LENGTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]       w_pending;
   logic                   w_idle, w_clear_en;
   logic                   w_wr_en, w_rsv_en;
   logic                   w_rd1_zero, w_rd2_zero, w_byp1, w_byp2;

   assign w_idle     = (r_state == IDLE);
   assign w_clear_en = (r_state == CLEAR);

   // Register 0 (when hardwired) swallows writes and reserves before they reach state.
   assign w_wr_en  = w_idle && bus.reg_Write &&
                     !(ZERO_REG && (bus.Write_Register == '0));
   assign w_rsv_en = w_idle && bus.Reserve_En &&
                     !(ZERO_REG && (bus.Reserve_Register == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            if (bus.Clear_Start) begin
               w_state_next = CLEAR;
               w_cnt_next   = '0;
            end
         end
         CLEAR: begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_clear_en) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_en) begin
         r_mem[bus.Write_Register] <= bus.Write_Data;
      end
   end

   reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
      .clk            (clk),
      .reset          (reset),
      .i_reserve_en   (w_rsv_en),
      .i_reserve_addr (bus.Reserve_Register),
      .i_write_en     (w_wr_en),
      .i_write_addr   (bus.Write_Register),
      .i_clear_en     (w_clear_en),
      .i_clear_addr   (r_cnt),
      .o_pending      (w_pending),
      .o_count        (bus.Pending_Count)
   );

   assign w_rd1_zero = ZERO_REG && (bus.Read_Register_1 == '0);
   assign w_rd2_zero = ZERO_REG && (bus.Read_Register_2 == '0);
   assign w_byp1     = w_wr_en && (bus.Read_Register_1 == bus.Write_Register);
   assign w_byp2     = w_wr_en && (bus.Read_Register_2 == bus.Write_Register);

   always_comb begin
      if (w_rd1_zero) begin
         bus.Read_Data_1  = '0;
         bus.Read_Valid_1 = 1'b1;
      end else if (w_byp1) begin
         bus.Read_Data_1  = bus.Write_Data;
         bus.Read_Valid_1 = 1'b1;
      end else begin
         bus.Read_Data_1  = r_mem[bus.Read_Register_1];
         bus.Read_Valid_1 = !w_pending[bus.Read_Register_1];
      end
   end

   always_comb begin
      if (w_rd2_zero) begin
         bus.Read_Data_2  = '0;
         bus.Read_Valid_2 = 1'b1;
      end else if (w_byp2) begin
         bus.Read_Data_2  = bus.Write_Data;
         bus.Read_Valid_2 = 1'b1;
      end else begin
         bus.Read_Data_2  = r_mem[bus.Read_Register_2];
         bus.Read_Valid_2 = !w_pending[bus.Read_Register_2];
      end
   end

   assign bus.Busy = w_clear_en;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: stimulus pushes expected outputs from a reference model, a monitor compares.
module tb_reg_file_sb;
   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   reg_file_sb_if #(.WORD_LENGTH(8), .ADDR_WIDTH(3)) bus ();

   reg_file_sb #(.WORD_LENGTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] d1;
      logic       v1;
      logic [7:0] d2;
      logic       v2;
      logic       busy;
      logic [3:0] cnt;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: register contents, pending flags, sweep progress.
   int unsigned m_mem [8];
   bit          m_pend [8];
   bit          m_busy = 1'b0;
   int unsigned m_idx  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void read_exp(input int unsigned ra, output logic [7:0] d, output logic v);
      if (ra == 0) begin
         d = 8'h00; v = 1'b1;
      end else if (!m_busy && bus.reg_Write && ra == bus.Write_Register) begin
         d = bus.Write_Data; v = 1'b1;
      end else begin
         d = m_mem[ra][7:0]; v = !m_pend[ra];
      end
   endfunction

   function automatic int unsigned pend_count();
      int unsigned n = 0;
      foreach (m_pend[i]) n += m_pend[i];
      return n;
   endfunction

   function automatic void model_edge();
      if (reset) begin
         foreach (m_mem[i]) begin m_mem[i] = 0; m_pend[i] = 1'b0; end
         m_busy = 1'b0;
         m_idx  = 0;
      end else if (m_busy) begin
         m_mem[m_idx]  = 0;
         m_pend[m_idx] = 1'b0;
         m_idx++;
         if (m_idx == 8) m_busy = 1'b0;
      end else begin
         if (bus.reg_Write && bus.Write_Register != 0) begin
            m_mem[bus.Write_Register]  = bus.Write_Data;
            m_pend[bus.Write_Register] = 1'b0;
         end
         if (bus.Reserve_En && bus.Reserve_Register != 0) m_pend[bus.Reserve_Register] = 1'b1;
         if (bus.Clear_Start) begin
            m_busy = 1'b1;
            m_idx  = 0;
         end
      end
   endfunction

   // One clock: record what the DUT must show this cycle, then advance the model.
   task automatic step(input bit rst, input bit we, input int unsigned wa, input int unsigned wd,
                       input bit re, input int unsigned ra, input int unsigned r1,
                       input int unsigned r2, input bit cs);
      exp_t e;
      bus.reg_Write        = we;
      bus.Write_Register   = wa[2:0];
      bus.Write_Data       = wd[7:0];
      bus.Reserve_En       = re;
      bus.Reserve_Register = ra[2:0];
      bus.Read_Register_1  = r1[2:0];
      bus.Read_Register_2  = r2[2:0];
      bus.Clear_Start      = cs;
      reset                = rst;
      read_exp(r1, e.d1, e.v1);
      read_exp(r2, e.d2, e.v2);
      e.busy = m_busy;
      e.cnt  = 4'(pend_count());
      q.push_back(e);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rd(input int unsigned r1, input int unsigned r2);
      step(0, 0, 0, 0, 0, 0, r1, r2, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("Read_Data_1",   32'(bus.Read_Data_1),   32'(e.d1));
            check("Read_Valid_1",  32'(bus.Read_Valid_1),  32'(e.v1));
            check("Read_Data_2",   32'(bus.Read_Data_2),   32'(e.d2));
            check("Read_Valid_2",  32'(bus.Read_Valid_2),  32'(e.v2));
            check("Busy",          32'(bus.Busy),          32'(e.busy));
            check("Pending_Count", 32'(bus.Pending_Count), 32'(e.cnt));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int unsigned busy_cycles;
      bus.reg_Write = 0; bus.Write_Register = 0; bus.Write_Data = 0;
      bus.Reserve_En = 0; bus.Reserve_Register = 0;
      bus.Read_Register_1 = 0; bus.Read_Register_2 = 0; bus.Clear_Start = 0;
      @(posedge clk);
      model_edge();
      #1;
      step(1, 0, 0, 0, 0, 0, 1, 7, 0);

      // Write/read
      step(0, 1, 2, 3, 0, 0, 1, 3, 0);
      step(0, 1, 4, 2, 0, 0, 2, 4, 0);
      step(0, 1, 5, 20, 0, 0, 4, 5, 0);
      step(0, 1, 7, 78, 0, 0, 7, 5, 0);
      rd(2, 7);
      rd(0, 5);

      // Bypass and hardwired zero
      step(0, 1, 5, 8'h5A, 0, 0, 5, 4, 0);
      step(0, 1, 0, 8'hFF, 0, 0, 0, 5, 0);
      rd(0, 0);

      // Scoreboard
      step(0, 0, 0, 0, 1, 3, 3, 2, 0);
      rd(3, 3);
      step(0, 1, 3, 9, 0, 0, 2, 6, 0);
      rd(3, 2);
      step(0, 1, 6, 8'h44, 1, 6, 1, 7, 0);
      rd(6, 3);
      step(0, 0, 0, 0, 1, 0, 0, 1, 0);
      rd(0, 6);

      // Clear sweep with a dropped write in the middle
      for (int unsigned i = 1; i < 8; i++) step(0, 1, i, 8'h10 + i, 0, 0, i, 0, 0);
      step(0, 0, 0, 0, 1, 4, 4, 1, 0);
      step(0, 0, 0, 0, 0, 0, 4, 2, 1);
      busy_cycles = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (m_busy) busy_cycles++;
         step(0, (i == 3), 2, 8'hEE, (i == 5), 5, i, 7 - i, (i == 6));
      end
      check("sweep_busy_cycles", busy_cycles, 8);
      for (int unsigned i = 0; i < 8; i += 2) rd(i, i + 1);
      step(0, 1, 1, 8'h77, 0, 0, 1, 2, 0);
      rd(1, 2);

      // Reset mid-sweep
      step(0, 0, 0, 0, 1, 2, 2, 3, 1);
      for (int unsigned i = 0; i < 3; i++) rd(i, 7);
      step(1, 0, 0, 0, 0, 0, 1, 7, 0);
      rd(1, 2);
      step(0, 1, 5, 20, 0, 0, 5, 0, 0);
      rd(5, 1);

      // Randomized traffic
      for (int unsigned n = 0; n < 600; n++) begin
         step(($urandom_range(0, 79) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 255), ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 39) == 0));
      end

      rd(0, 0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
